// File: rtl/sand_pkg.sv
// sand_pkg: shared grid geometry, cell encoding and memory FSM states for the sand grid store.
package sand_pkg;
  localparam int GRID_COLS_WORDS = 80;
  localparam int GRID_ROWS = 480;
  localparam int CELLS_PER_WORD = 8;
  typedef enum logic [1:0] {EMPTY, SAND, WALL, WATER} cell_t;
  typedef enum logic {IDLE, CLEAR} mem_state_t;
  localparam int WORD_W = CELLS_PER_WORD * $bits(cell_t);
endpackage

// File: rtl/sand_ram_1p.sv
// sand_ram_1p: single-port synchronous RAM with one registered read cycle, BRAM-inferable.
module sand_ram_1p #(
  parameter int DEPTH = 38400,
  parameter int AW = $clog2(DEPTH),
  parameter int W = 16
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clock) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/sand_grid_mem.sv
// sand_grid_mem: Avalon-MM pipelined slave holding the packed sand grid, with a hardware zero-fill engine.
module sand_grid_mem
  import sand_pkg::*;
#(
  parameter int DEPTH = GRID_COLS_WORDS * GRID_ROWS,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [WORD_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic              avs_readdatavalid,
  output logic [WORD_W-1:0] avs_readdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              protocol_error
);
  localparam int AW = $clog2(DEPTH);
  mem_state_t state_q, state_d;
  logic [AW-1:0] clear_ptr_q, clear_ptr_d, ram_addr;
  logic reset_hold_q, protocol_error_q, v1_q, oor_q;
  logic clearing, last, accept, acc_rd, acc_wr, in_range, ram_we;
  logic [WORD_W-1:0] ram_wdata, ram_rdata, rd_data;
  assign clearing = state_q == CLEAR;
  assign last = clear_ptr_q == AW'(DEPTH - 1);
  assign avs_waitrequest = reset | reset_hold_q | clearing;
  assign accept = (avs_read | avs_write) && !avs_waitrequest;
  assign acc_wr = accept && avs_write;
  assign acc_rd = accept && avs_read && !avs_write;
  assign in_range = avs_address < ADDR_W'(DEPTH);
  // The clear engine owns the single RAM port while clearing; the bus is stalled then.
  assign ram_we = clearing ? !reset : acc_wr && in_range;
  assign ram_addr = clearing ? clear_ptr_q : avs_address[AW-1:0];
  assign ram_wdata = clearing ? '0 : avs_writedata;
  assign state_d = clearing ? (last ? IDLE : CLEAR) : (clear_start ? CLEAR : IDLE);
  assign clear_ptr_d = clearing && !last ? clear_ptr_q + 1'b1 : '0;
  assign clear_busy = clearing;
  assign protocol_error = protocol_error_q;
  sand_ram_1p #(.DEPTH(DEPTH), .AW(AW), .W(WORD_W)) u_ram (
    .clock  (clock),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      clear_ptr_q <= '0;
      reset_hold_q <= 1'b1;
      protocol_error_q <= 1'b0;
      v1_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_ptr_q <= clear_ptr_d;
      reset_hold_q <= 1'b0;
      protocol_error_q <= protocol_error_q | (accept && avs_read && avs_write);
      v1_q <= acc_rd;
      oor_q <= !in_range;
    end
  end
  // First response stage sits on the RAM output register; invalid slots carry zero.
  assign rd_data = v1_q && !oor_q ? ram_rdata : '0;
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign avs_readdatavalid = v1_q;
      assign avs_readdata = rd_data;
    end else begin : g_pipe
      logic vp_q [READ_LATENCY-1];
      logic [WORD_W-1:0] dp_q [READ_LATENCY-1];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < READ_LATENCY - 1; i++) begin
            vp_q[i] <= 1'b0;
            dp_q[i] <= '0;
          end
        end else begin
          vp_q[0] <= v1_q;
          dp_q[0] <= rd_data;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            vp_q[i] <= vp_q[i-1];
            dp_q[i] <= dp_q[i-1];
          end
        end
      end
      assign avs_readdatavalid = vp_q[READ_LATENCY-2];
      assign avs_readdata = dp_q[READ_LATENCY-2];
    end
  endgenerate
endmodule
